// File: rtl/univ_ff_pkg.sv
// Shared definitions for the universal flip-flop bank.
//   ff_mode_t : 2-bit run-time mode selector
//   MODE_*    : D / T / JK / SR encodings
package univ_ff_pkg;

  typedef logic [1:0] ff_mode_t;

  localparam ff_mode_t MODE_D  = 2'b00;
  localparam ff_mode_t MODE_T  = 2'b01;
  localparam ff_mode_t MODE_JK = 2'b10;
  localparam ff_mode_t MODE_SR = 2'b11;

endpackage

// File: rtl/univ_ff_cell.sv
// One state bit of the universal flip-flop bank: next-state logic plus flop.
// Ports:
//   clk_in, rstn_in : rising-edge clock, async active-low reset (loads RST_VAL)
//   en_in           : clock enable
//   mode_in         : D / T / JK / SR select
//   a_in, b_in      : D/T/J/S and K/R operands
//   q_out           : registered bit
//   nxt_out         : next state this bit will take at the coming edge
//   ill_out         : SR mode with S=R=1 while enabled
module univ_ff_cell
  import univ_ff_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic       clk_in,
  input  logic       rstn_in,
  input  logic       en_in,
  input  logic [1:0] mode_in,
  input  logic       a_in,
  input  logic       b_in,
  output logic       q_out,
  output logic       nxt_out,
  output logic       ill_out
);

  logic r_q;
  logic w_nxt;
  logic w_ill;

  always_comb begin
    w_nxt = r_q;
    w_ill = 1'b0;
    if (en_in) begin
      case (mode_in)
        MODE_D:  w_nxt = a_in;
        MODE_T:  w_nxt = r_q ^ a_in;
        MODE_JK: begin
          case ({a_in, b_in})
            2'b01:   w_nxt = 1'b0;
            2'b10:   w_nxt = 1'b1;
            2'b11:   w_nxt = ~r_q;
            default: w_nxt = r_q;
          endcase
        end
        MODE_SR: begin
          case ({a_in, b_in})
            2'b01:   w_nxt = 1'b0;
            2'b10:   w_nxt = 1'b1;
            2'b11:   w_ill = 1'b1; // illegal: bit holds, flag raised
            default: w_nxt = r_q;
          endcase
        end
        default: w_nxt = r_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) r_q <= RST_VAL;
    else          r_q <= w_nxt;
  end

  assign q_out   = r_q;
  assign nxt_out = w_nxt;
  assign ill_out = w_ill;

endmodule

// File: rtl/univ_ff_bank.sv
// WIDTH-bit multi-mode (D/T/JK/SR) register bank with clock enable,
// true/complement outputs, a registered change pulse and a sticky
// illegal-SR error flag.
// Ports:
//   clk_in, rstn_in : rising-edge clock, async active-low reset
//   en_in           : clock enable
//   mode_in         : 00=D 01=T 10=JK 11=SR, shared by all bits
//   a_in, b_in      : per-bit operands
//   err_clr_in      : synchronous clear of err_out (a new error wins)
//   q_out, qbar_out : state and its complement
//   chg_out         : 1 for the cycle after an edge that changed q_out
//   err_out         : sticky S=R=1 flag
//   parity_out      : ^q_out, only when UNIV_FF_BANK_PARITY_EN is defined
module univ_ff_bank
  import univ_ff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk_in,
  input  logic             rstn_in,
  input  logic             en_in,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             err_clr_in,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] qbar_out,
  output logic             chg_out,
`ifdef UNIV_FF_BANK_PARITY_EN
  output logic             parity_out,
`endif
  output logic             err_out
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_ill;
  logic             r_chg;
  logic             r_err;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    univ_ff_cell #(
      .RST_VAL (RESET_VAL[gi])
    ) u_cell (
      .clk_in  (clk_in),
      .rstn_in (rstn_in),
      .en_in   (en_in),
      .mode_in (mode_in),
      .a_in    (a_in[gi]),
      .b_in    (b_in[gi]),
      .q_out   (w_q[gi]),
      .nxt_out (w_nxt[gi]),
      .ill_out (w_ill[gi])
    );
  end

  // Disabled cells present nxt == q, so chg falls to 0 without an en term.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      r_chg <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_chg <= |(w_nxt ^ w_q);
      if (|w_ill)          r_err <= 1'b1;
      else if (err_clr_in) r_err <= 1'b0;
    end
  end

`ifdef UNIV_FF_BANK_PARITY_EN
  // Registered from the next state so it lines up with q_out.
  logic r_par;
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) r_par <= ^RESET_VAL;
    else          r_par <= ^w_nxt;
  end
  assign parity_out = r_par;
`endif

  assign q_out    = w_q;
  assign qbar_out = ~w_q;
  assign chg_out  = r_chg;
  assign err_out  = r_err;

endmodule

// File: tb/tb_univ_ff_bank.sv
// Bench for univ_ff_bank (WIDTH=8, RESET_VAL=0): directed cases then
// randomized traffic against a mask-arithmetic reference model.
module tb_univ_ff_bank;

  logic       clk_in = 1'b0;
  logic       rstn_in;
  logic       en_in;
  logic [1:0] mode_in;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       err_clr_in;
  logic [7:0] q_out;
  logic [7:0] qbar_out;
  logic       chg_out;
  logic       err_out;
`ifdef UNIV_FF_BANK_PARITY_EN
  logic       parity_out;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // reference state
  logic [7:0] m_q;
  logic       m_chg;
  logic       m_err;

  always #5 clk_in = ~clk_in;

  univ_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk_in     (clk_in),
    .rstn_in    (rstn_in),
    .en_in      (en_in),
    .mode_in    (mode_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .err_clr_in (err_clr_in),
    .q_out      (q_out),
    .qbar_out   (qbar_out),
    .chg_out    (chg_out),
`ifdef UNIV_FF_BANK_PARITY_EN
    .parity_out (parity_out),
`endif
    .err_out    (err_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Whole-word next state from the mode rules expressed as set/clear masks.
  function automatic logic [7:0] ref_next(logic [7:0] q, logic en, logic [1:0] md,
                                          logic [7:0] a, logic [7:0] b);
    if (!en) return q;
    case (md)
      2'd0:    return a;
      2'd1:    return q ^ a;
      2'd2:    return (a & ~q) | (~b & q);
      default: return (q | (a & ~b)) & ~(~a & b);
    endcase
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".q"},    {24'h0, q_out},    {24'h0, m_q});
    chk({tag, ".qbar"}, {24'h0, qbar_out}, {24'h0, ~m_q});
    chk({tag, ".chg"},  {31'h0, chg_out},  {31'h0, m_chg});
    chk({tag, ".err"},  {31'h0, err_out},  {31'h0, m_err});
`ifdef UNIV_FF_BANK_PARITY_EN
    chk({tag, ".par"},  {31'h0, parity_out}, {31'h0, ^m_q});
`endif
  endtask

  // One clock edge with the currently driven inputs, then compare.
  task automatic tick(input string tag);
    logic [7:0] nq;
    logic       ill;
    nq  = ref_next(m_q, en_in, mode_in, a_in, b_in);
    ill = en_in && (mode_in == 2'd3) && ((a_in & b_in) != 8'h00);
    m_chg = (nq != m_q);
    m_err = ill ? 1'b1 : (err_clr_in ? 1'b0 : m_err);
    m_q   = nq;
    @(posedge clk_in);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic en, input logic [1:0] md, input logic [7:0] a,
                       input logic [7:0] b, input logic clr);
    en_in = en; mode_in = md; a_in = a; b_in = b; err_clr_in = clr;
  endtask

  task automatic async_reset(input string tag);
    #1 rstn_in = 1'b0;
    #1;
    m_q = 8'h00; m_chg = 1'b0; m_err = 1'b0;
    check_all(tag);
    #1 rstn_in = 1'b1;
  endtask

  initial begin
    rstn_in = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    m_q = 8'h00; m_chg = 1'b0; m_err = 1'b0;
    #2;
    check_all("rst");
    @(negedge clk_in);
    rstn_in = 1'b1;
    @(posedge clk_in); #1;

    // load A5 then reset mid-cycle without an edge
    drive(1'b1, 2'd0, 8'hA5, 8'h00, 1'b0); tick("ldA5");
    chk("ldA5.const", {24'h0, q_out}, 32'hA5);
    async_reset("midrst");

    // D then enable low
    drive(1'b1, 2'd0, 8'h3C, 8'h00, 1'b0); tick("d3C");
    chk("d3C.const", {24'h0, q_out}, 32'h3C);
    drive(1'b0, 2'd0, 8'hFF, 8'h00, 1'b0); tick("enlo");
    chk("enlo.chg0", {31'h0, chg_out}, 32'h0);

    // T toggles
    drive(1'b1, 2'd1, 8'h0F, 8'h00, 1'b0); tick("t1");
    chk("t1.const", {24'h0, q_out}, 32'h33);
    tick("t2");
    chk("t2.const", {24'h0, q_out}, 32'h3C);
    drive(1'b1, 2'd1, 8'h00, 8'h00, 1'b0); tick("t3");

    // JK
    drive(1'b1, 2'd0, 8'hF0, 8'h00, 1'b0); tick("ldF0");
    drive(1'b1, 2'd2, 8'h0C, 8'hC3, 1'b0); tick("jk");
    chk("jk.const", {24'h0, q_out}, 32'h3C);

    // SR illegal, clear, set-beats-clear
    drive(1'b1, 2'd0, 8'h00, 8'h00, 1'b0); tick("ld00");
    drive(1'b1, 2'd3, 8'h81, 8'h01, 1'b0); tick("srill");
    chk("srill.const", {24'h0, q_out}, 32'h80);
    chk("srill.err1", {31'h0, err_out}, 32'h1);
    drive(1'b1, 2'd3, 8'h00, 8'h00, 1'b1); tick("srclr");
    chk("srclr.err0", {31'h0, err_out}, 32'h0);
    drive(1'b1, 2'd3, 8'h01, 8'h01, 1'b1); tick("setwin");
    chk("setwin.err1", {31'h0, err_out}, 32'h1);
    // disabled SR with S=R=1 cannot raise an error; clear still works
    drive(1'b0, 2'd3, 8'hFF, 8'hFF, 1'b1); tick("enlo_clr");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
            8'($urandom), 8'($urandom), ($urandom_range(0, 5) == 0));
      tick("rnd");
      if ($urandom_range(0, 49) == 0) async_reset("rndrst");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/univ_ff_bank.md
Name: univ_ff_bank

Overview:
- Parametrised multi-mode edge-triggered register bank; the clocked successor to the single-bit D latch.
- Holds WIDTH independent state bits.
- A run-time mode input selects D, T, JK or SR next-state behaviour for every bit.
- Adds clock enable, true/complement outputs, a change-pulse output and a sticky illegal-SR flag.
- Used as the common storage element for the FLIPFLOPS lab sequence (counters, shift chains).

Parameters:
- WIDTH, 8, number of state bits (1..32).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q_out on reset.

Ports:
- clk_in  input  1  rising-edge clock.
- rstn_in  input  1  reset; asynchronous, active-low.
- en_in  input  1  clock enable; state updates only when 1.
- mode_in  input  2  00=D, 01=T, 10=JK, 11=SR; applies to all bits.
- a_in  input  WIDTH  D / T / J / S operand, by mode.
- b_in  input  WIDTH  K / R operand; ignored in D and T modes.
- err_clr_in  input  1  synchronous clear of err_out.
- q_out  output  WIDTH  registered state.
- qbar_out  output  WIDTH  always exactly ~q_out; no separate state.
- chg_out  output  1  registered; 1 for the cycle in which q_out shows a value different from the previous cycle.
- err_out  output  1  sticky; set when an SR update sees S=R=1 on any bit.

Behaviour:
- Reset (rstn_in=0, any time, independent of the clock):
  - q_out=RESET_VAL, qbar_out=~RESET_VAL, chg_out=0, err_out=0.
  - Reset mid-operation discards any pending update.
  - The first edge after deassertion behaves normally.
- Latency: one clock. Inputs sampled on a rising edge appear on q_out immediately after that edge.
- en_in=0: q_out holds, chg_out=0 next cycle. err_out still obeys err_clr_in; no new error can be set.
- Per-bit next state q+ when en_in=1:
  - D: q+=a.
  - T: q+=q^a.
  - JK: a=0,b=0 hold; a=0,b=1 →0; a=1,b=0 →1; a=1,b=1 toggle.
  - SR: a=0,b=0 hold; a=0,b=1 →0; a=1,b=0 →1; a=1,b=1 illegal → that bit holds, and err_out is set at the same edge.
- chg_out: 1 after an edge where q+ != q on any bit, else 0. Pure function of old/new q; mode-independent.
- err_out:
  - Set has priority over clear when both happen at the same edge.
  - Clear when err_clr_in=1 and no new illegal condition.
  - Otherwise holds.
- mode_in may change every cycle; no mode-switch state or penalty.
- No combinational path from inputs to outputs other than qbar_out=~q_out.

Optional Feature:
- Macro: UNIV_FF_BANK_PARITY_EN.
- Defined:
  - Adds output parity_out (1 bit), registered, always equal to ^q_out in the same cycle (computed from q+).
  - Reset value is ^RESET_VAL.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package univ_ff_pkg:
  - Mode constants MODE_D=2'b00, MODE_T=2'b01, MODE_JK=2'b10, MODE_SR=2'b11.
  - A typedef for the 2-bit mode.
- Sub-module univ_ff_cell:
  - One-bit next-state logic plus flop, with async active-low reset and per-bit reset value.
  - Exports a per-bit illegal flag.
  - Generated WIDTH times.
- The top reduces the per-bit illegal flags into err_out and computes chg_out.

Test Plan (WIDTH=8, RESET_VAL=8'h00):
- Reset: rstn_in=0 asserted mid-cycle after q=8'hA5 → q_out=8'h00, qbar_out=8'hFF, chg_out=0, err_out=0 without waiting for a clock edge.
- D then enable low: mode=D, a=8'h3C, en=1 for one edge → q=8'h3C, chg=1. Then en=0 with a=8'hFF → q stays 8'h3C, chg=0.
- T: from q=8'h3C, mode=T, a=8'h0F, two edges → q=8'h33 then 8'h3C, chg=1 both cycles. Third edge with a=8'h00 → chg=0.
- JK: from q=8'hF0, mode=JK, a=8'h0C, b=8'hC3 → q=8'h3C. Bit 7: J=0,K=1 clears. Bits 2-3: J=1,K=0 set. Bits 0-1: J=0,K=1 stay 0. Bit 6: J=0,K=1 clears.
- SR illegal: q=8'h00, mode=SR, a=8'h81, b=8'h01 → q=8'h80 (bit0 holds), err_out=1. err_clr_in=1 with a legal SR on the next edge → err_out=0.
- Set beats clear: err_clr_in=1 in the same cycle as SR a=b=8'h01 → err_out stays 1. With UNIV_FF_BANK_PARITY_EN defined, parity_out tracks ^q_out on every edge above.
